// File: rtl/note_pkg.sv
// Shared constants for the pitch classifier: octave-0 nominal and quarter-tone
// boundary tables in Q16.16 Hz, note-name encoding, and a threshold helper.
package note_pkg;

  localparam int NUM_NOTES    = 12;
  localparam int NUM_OCTAVES  = 8;
  localparam int TABLE_FRAC_W = 16;

  typedef enum logic [3:0] {
    NOTE_C  = 4'd0,
    NOTE_CS = 4'd1,
    NOTE_D  = 4'd2,
    NOTE_DS = 4'd3,
    NOTE_E  = 4'd4,
    NOTE_F  = 4'd5,
    NOTE_FS = 4'd6,
    NOTE_G  = 4'd7,
    NOTE_GS = 4'd8,
    NOTE_A  = 4'd9,
    NOTE_AS = 4'd10,
    NOTE_B  = 4'd11
  } note_e;

  // Octave-0 nominal pitches, A0 = 27.5 Hz.
  localparam logic [31:0] NOM [NUM_NOTES] = '{
    32'd1071618, 32'd1135340, 32'd1202851, 32'd1274376,
    32'd1350154, 32'd1430439, 32'd1515497, 32'd1605613,
    32'd1701088, 32'd1802240, 32'd1909407, 32'd2022946
  };

  // Quarter-tone above each octave-0 note: the exclusive upper edge of its bin.
  localparam logic [31:0] UB [NUM_NOTES] = '{
    32'd1103019, 32'd1168608, 32'd1238097, 32'd1311718,
    32'd1389717, 32'd1472354, 32'd1559905, 32'd1652661,
    32'd1750934, 32'd1855050, 32'd1965357, 32'd2082223
  };

  // Quarter-tone below C0: anything lower is out of range.
  localparam logic [31:0] LB0 = 32'd1041111;

  // Move an octave-0 table constant to the given octave and input fraction width.
  function automatic logic [31:0] place(input logic [31:0] c,
                                        input logic [2:0]  octave,
                                        input int          frac_w);
    logic [31:0] s;
    s = c << octave;
    if (frac_w >= TABLE_FRAC_W) return s << (frac_w - TABLE_FRAC_W);
    return s >> (TABLE_FRAC_W - frac_w);
  endfunction

endpackage

// File: rtl/note_octave_find.sv
// Combinational octave search: compares the input against the lower edge of
// C in every octave and flags inputs outside the classifiable range.
module note_octave_find
  import note_pkg::*;
#(
  parameter int FREQ_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic [FREQ_W-1:0] freq_fun,
  output logic [2:0]        octave,
  output logic              below_range,
  output logic              above_range
);

  // The lower edge of C(k) is the upper edge of B(k-1); edges rise with k,
  // so the last threshold passed is the octave.
  // NOTE: every output of an always_comb gets a default before any
  // conditional assignment, otherwise a latch is inferred.
  always_comb begin
    octave = 3'd0;
    for (int k = 1; k < NUM_OCTAVES; k++) begin
      if (freq_fun >= place(UB[NUM_NOTES-1], 3'(k - 1), FRAC_W)) octave = 3'(k);
    end
  end

  assign below_range = freq_fun < place(LB0, 3'd0, FRAC_W);
  assign above_range = freq_fun >= place(UB[NUM_NOTES-1], 3'(NUM_OCTAVES - 1), FRAC_W);

endmodule

// File: rtl/note_lut.sv
// Pitch classifier: maps a Q16.16 fundamental to the nearest equal-tempered
// note and octave, plus a sharp flag; one registered cycle of latency.
module note_lut
  import note_pkg::*;
#(
  parameter int FREQ_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [FREQ_W-1:0] freq_fun,
  output logic [3:0]        note_name,
  output logic [2:0]        note_octave,
  output logic              greater
);

  logic [2:0]  octave;
  logic        below_range;
  logic        above_range;
  note_e       note;
  logic [31:0] nom_sel;

  note_octave_find #(
    .FREQ_W (FREQ_W),
    .FRAC_W (FRAC_W)
  ) u_octave_find (
    .freq_fun    (freq_fun),
    .octave      (octave),
    .below_range (below_range),
    .above_range (above_range)
  );

  // Within the selected octave the bin index is the count of upper edges
  // at or below the input; the matching nominal is carried alongside.
  always_comb begin
    note    = NOTE_C;
    nom_sel = place(NOM[0], octave, FRAC_W);
    for (int n = 0; n < NUM_NOTES - 1; n++) begin
      if (freq_fun >= place(UB[n], octave, FRAC_W)) begin
        note    = note_e'(4'(n + 1));
        nom_sel = place(NOM[n + 1], octave, FRAC_W);
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      note_name   <= NOTE_C;
      note_octave <= 3'd0;
      greater     <= 1'b0;
    end else if (below_range) begin
      note_name   <= NOTE_C;
      note_octave <= 3'd0;
      greater     <= 1'b0;
    end else if (above_range) begin
      note_name   <= NOTE_B;
      note_octave <= 3'(NUM_OCTAVES - 1);
      greater     <= 1'b1;
    end else begin
      note_name   <= note;
      note_octave <= octave;
      greater     <= freq_fun > nom_sel;
    end
  end

endmodule

// File: tb/tb_note_lut.sv
// Self-checking bench for note_lut: directed boundary cases plus a sweep,
// all expectations queued at drive time and popped one cycle later.
module tb_note_lut;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] freq_fun;
  logic [3:0]  note_name;
  logic [2:0]  note_octave;
  logic        greater;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;

  sb_t sb [$];

  // Independent reference tables (octave 0, Q16.16 Hz).
  localparam logic [31:0] M_NOM [12] = '{
    32'd1071618, 32'd1135340, 32'd1202851, 32'd1274376,
    32'd1350154, 32'd1430439, 32'd1515497, 32'd1605613,
    32'd1701088, 32'd1802240, 32'd1909407, 32'd2022946
  };
  localparam logic [31:0] M_UB [12] = '{
    32'd1103019, 32'd1168608, 32'd1238097, 32'd1311718,
    32'd1389717, 32'd1472354, 32'd1559905, 32'd1652661,
    32'd1750934, 32'd1855050, 32'd1965357, 32'd2082223
  };
  localparam logic [31:0] M_LB0 = 32'd1041111;

  note_lut dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .freq_fun    (freq_fun),
    .note_name   (note_name),
    .note_octave (note_octave),
    .greater     (greater)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got name=%0d oct=%0d gt=%0d, expected name=%0d oct=%0d gt=%0d",
               tag, got[7:4], got[3:1], got[0], exp[7:4], exp[3:1], exp[0]);
    end
  endtask

  // Exhaustive bin search over every (octave, note) pair.
  function automatic logic [7:0] model(input logic [31:0] f);
    logic [31:0] lo, hi;
    if (f < M_LB0) return 8'h00;
    if (f >= (M_UB[11] << 7)) return {4'd11, 3'd7, 1'b1};
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 12; n++) begin
        if (n > 0)      lo = M_UB[n-1] << k;
        else if (k > 0) lo = M_UB[11] << (k - 1);
        else            lo = M_LB0;
        hi = M_UB[n] << k;
        if (f >= lo && f < hi) return {4'(n), 3'(k), f > (M_NOM[n] << k)};
      end
    end
    return 8'hFF;
  endfunction

  // Drive one input on the falling edge and queue the expected result.
  task automatic drive(input logic [31:0] f, input logic rst, input logic [7:0] exp,
                       input string tag);
    sb_t e;
    @(negedge clock);
    reset_n  = rst;
    freq_fun = f;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drive_model(input logic [31:0] f, input logic rst, input string tag);
    drive(f, rst, rst ? model(f) : 8'h00, tag);
  endtask

  always @(posedge clock) begin
    sb_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, {note_name, note_octave, greater}, e.exp);
    end
  end

  initial begin
    reset_n  = 1'b0;
    freq_fun = 32'h0;

    drive(32'h01B80000, 1'b0, {4'd0, 3'd0, 1'b0}, "reset_0");
    drive(32'h01B80000, 1'b0, {4'd0, 3'd0, 1'b0}, "reset_1");
    drive(32'h01B80000, 1'b1, {4'd9, 3'd4, 1'b0}, "a4_exact");
    drive(32'h0105A025, 1'b1, {4'd0, 3'd4, 1'b1}, "c4_plus5");
    drive(32'h0105A020, 1'b1, {4'd0, 3'd4, 1'b0}, "c4_exact");
    drive(32'd17648304, 1'b1, {4'd1, 3'd4, 1'b0}, "c4_cs4_edge");
    drive(32'd17648303, 1'b1, {4'd0, 3'd4, 1'b1}, "c4_cs4_edge_m1");
    drive(32'd16657784, 1'b1, {4'd0, 3'd4, 1'b0}, "b3_c4_wrap");
    drive(32'd16657783, 1'b1, {4'd11, 3'd3, 1'b1}, "b3_c4_wrap_m1");
    drive(32'h00010000, 1'b1, {4'd0, 3'd0, 1'b0}, "below_1hz");
    drive(32'h00000000, 1'b1, {4'd0, 3'd0, 1'b0}, "below_zero");
    drive(32'd1041110,  1'b1, {4'd0, 3'd0, 1'b0}, "lb0_m1");
    drive(32'd1071619,  1'b1, {4'd0, 3'd0, 1'b1}, "c0_plus1");
    drive(32'd2082223,  1'b1, {4'd0, 3'd1, 1'b0}, "b0_c1_wrap");
    drive(32'd2082222,  1'b1, {4'd11, 3'd0, 1'b1}, "b0_c1_wrap_m1");
    drive(32'd1802240,  1'b1, {4'd9, 3'd0, 1'b0}, "a0_exact");
    drive(32'd266524543, 1'b1, {4'd11, 3'd7, 1'b1}, "top_edge_m1");
    drive(32'd266524544, 1'b1, {4'd11, 3'd7, 1'b1}, "top_edge");
    drive(32'h70B88802, 1'b1, {4'd11, 3'd7, 1'b1}, "above_70b8");
    drive(32'hFFFFFFFF, 1'b1, {4'd11, 3'd7, 1'b1}, "above_max");

    begin
      int i = 0;
      for (longint f = 64'h0105A025; f <= 64'h70B88802; f += 64'h5A025) begin
        if (i == 2000 || i == 2001) drive_model(32'(f), 1'b0, "sweep_reset");
        else                        drive_model(32'(f), 1'b1, "sweep");
        i++;
      end
    end

    repeat (2) @(posedge clock);
    #2;
    check("sb_drain", 8'(sb.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
